// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - multi-cycle MIPS HI/LO multiply/divide unit
// Shift-add multiply and restoring divide, one bit per cycle, with pipeline stall.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk_in,
  input  logic             Reset_in,
  input  logic             Valid_in,
  input  logic [5:0]       Func_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] O_out,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out,
  output logic             Busy_out,
  output logic             Stall_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;

  logic               listed, is_md, signed_op, busy, stall, accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign is_md     = (Func_in[5:2] == 4'b0110);
  assign listed    = is_md || (Func_in[5:2] == 4'b0100);
  assign signed_op = ~Func_in[0];
  assign busy      = (state_q != S_IDLE);
  assign stall     = Valid_in & busy & listed;
  assign accept    = Valid_in & ~stall;

  assign abs_a = (signed_op && A_in[WIDTH-1]) ? -A_in : A_in;
  assign abs_b = (signed_op && B_in[WIDTH-1]) ? -B_in : B_in;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: acc holds {partial remainder, dividend bits shifting into quotient}.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
  assign div_ok    = ~div_trial[WIDTH];
  assign div_rem   = div_ok ? div_trial[WIDTH-1:0] : {acc_q[2*WIDTH-2:WIDTH], acc_q[WIDTH-1]};

  assign prod = qneg_q ? -acc_q : acc_q;
  assign quo  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept && is_md) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = Func_in[1];
          a_raw_d  = A_in;
          dz_d     = (B_in == '0);
          qneg_d   = signed_op & (A_in[WIDTH-1] ^ B_in[WIDTH-1]);
          rneg_d   = signed_op & A_in[WIDTH-1];
          if (Func_in[1]) begin
            acc_d  = {{WIDTH{1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, abs_b};
            opnd_d = abs_a;
          end
        end else if (accept && Func_in == F_MTHI) begin
          hi_d = A_in;
        end else if (accept && Func_in == F_MTLO) begin
          lo_d = A_in;
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? {div_rem, acc_q[WIDTH-2:0], div_ok}
                         : {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_in) begin
    if (Reset_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
    end
  end

  always_comb begin
    O_out = '0;
    if (Valid_in && !stall && Func_in == F_MFHI) O_out = hi_q;
    else if (Valid_in && !stall && Func_in == F_MFLO) O_out = lo_q;
  end

  assign Hi_out    = hi_q;
  assign Lo_out    = lo_q;
  assign Busy_out  = busy;
  assign Stall_out = stall;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed-vector bench for alu_muldiv with a cycle-level reference model
module tb_alu_muldiv;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [5:0]    func;
  logic [W-1:0]  a, b;
  logic [W-1:0]  o, hi, lo;
  logic          busy, stall;

  logic          v8;
  logic [5:0]    f8;
  logic [7:0]    a8, b8;
  logic [7:0]    o8, hi8, lo8;
  logic          busy8, stall8;

  int n_vec  = 0;
  int n_miss = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .Clk_in(clk), .Reset_in(rst), .Valid_in(valid), .Func_in(func),
    .A_in(a), .B_in(b), .O_out(o), .Hi_out(hi), .Lo_out(lo),
    .Busy_out(busy), .Stall_out(stall)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .Clk_in(clk), .Reset_in(rst), .Valid_in(v8), .Func_in(f8),
    .A_in(a8), .B_in(b8), .O_out(o8), .Hi_out(hi8), .Lo_out(lo8),
    .Busy_out(busy8), .Stall_out(stall8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {HI, LO} straight from MIPS arithmetic semantics.
  function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, m;
    logic [63:0] ux, uy, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'h0, x};
    uy = {32'h0, y};
    r  = '0;
    case (f)
      6'h18: r = sx * sy;
      6'h19: r = ux * uy;
      6'h1A: begin
        if (y == 0) r = {x, 32'hffffffff};
        else if (x == 32'h80000000 && y == 32'hffffffff) r = {32'h0, 32'h80000000};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      6'h1B: begin
        if (y == 0) r = {x, 32'hffffffff};
        else begin
          q = ux / uy;
          m = ux % uy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_listed(input logic [5:0] f);
    return (f >= 6'h10 && f <= 6'h13) || (f >= 6'h18 && f <= 6'h1B);
  endfunction

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_hi  <= '0;
      m_lo  <= '0;
      m_cnt <= 0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (valid) begin
      case (func)
        6'h18, 6'h19, 6'h1A, 6'h1B: begin
          m_pend <= ref_op(func, a, b);
          m_cnt  <= W + 1;
        end
        6'h11: m_hi <= a;
        6'h13: m_lo <= a;
        default: ;
      endcase
    end
  end

  initial begin
    logic        e_stall;
    logic [31:0] e_o;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_stall = valid && (m_cnt > 0) && is_listed(func);
        e_o = '0;
        if (valid && !e_stall && func == 6'h10) e_o = m_hi;
        else if (valid && !e_stall && func == 6'h12) e_o = m_lo;
        chk("model_hi", hi, m_hi);
        chk("model_lo", lo, m_lo);
        chk("model_busy", busy, m_cnt > 0);
        chk("model_stall", stall, e_stall);
        chk("model_o", o, e_o);
      end
    end
  end

  task automatic op32(input string name, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] e_hi, input logic [31:0] e_lo);
    int n;
    valid = 1'b1; func = f; a = x; b = y;
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk({name, "_busy_cycles"}, n, 33);
    chk({name, "_hi"}, hi, e_hi);
    chk({name, "_lo"}, lo, e_lo);
  endtask

  task automatic op8(input string name, input logic [5:0] f, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] e_hi, input logic [7:0] e_lo);
    int n;
    v8 = 1'b1; f8 = f; a8 = x; b8 = y;
    @(posedge clk); #1;
    v8 = 1'b0;
    n = 0;
    while (busy8 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk({name, "_busy_cycles"}, n, 9);
    chk({name, "_hi"}, hi8, e_hi);
    chk({name, "_lo"}, lo8, e_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1; valid = 1'b0; func = '0; a = '0; b = '0;
    v8 = 1'b0; f8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_o8", o8, 0);
    chk("rst_stall8", stall8, 0);
    valid = 1'b1; func = 6'h10; #1;
    chk("rst_mfhi_o", o, 0);
    func = 6'h12; #1;
    chk("rst_mflo_o", o, 0);
    @(posedge clk); #1;
    valid = 1'b0;

    op32("mult_m1x2", 6'h18, 32'hffffffff, 32'h2, 32'hffffffff, 32'hfffffffe);
    op32("multu_m1x2", 6'h19, 32'hffffffff, 32'h2, 32'h1, 32'hfffffffe);
    op32("div_m7d2", 6'h1A, 32'hfffffff9, 32'h2, 32'hffffffff, 32'hfffffffd);
    op32("divu_7d0", 6'h1B, 32'h7, 32'h0, 32'h7, 32'hffffffff);
    op32("div_ovf", 6'h1A, 32'h80000000, 32'hffffffff, 32'h0, 32'h80000000);
    op32("div_m7d0", 6'h1A, 32'hfffffff9, 32'h0, 32'hfffffff9, 32'hffffffff);
    op32("div_7dm2", 6'h1A, 32'h7, 32'hfffffffe, 32'h1, 32'hfffffffd);
    op32("divu_big", 6'h1B, 32'hfffffff9, 32'h10, 32'h9, 32'h0fffffff);
    op32("multu_max", 6'h19, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001);

    // Inputs carried with Valid_in low must leave HI untouched.
    func = 6'h11; a = 32'hdeadbeef;
    @(posedge clk); #1;
    chk("mthi_invalid", hi, 32'hfffffffe);

    // MFLO held behind a signed multiply of 5 x -3.
    valid = 1'b1; func = 6'h18; a = 32'h5; b = 32'hfffffffd;
    @(posedge clk); #1;
    func = 6'h12;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    chk("mflo_stall_cycles", n, 33);
    chk("mflo_after_stall", o, 32'hfffffff1);
    func = 6'h11; a = 32'h1234;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("mthi_write", hi, 32'h1234);

    // Abandon a multiply mid-run; an unlisted code is offered meanwhile.
    valid = 1'b1; func = 6'h19; a = 32'hffffffff; b = 32'hffffffff;
    @(posedge clk); #1;
    func = 6'h20;
    repeat (10) @(posedge clk);
    #1;
    chk("unlisted_no_stall", stall, 0);
    valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    op32("multu_3x5", 6'h19, 32'h3, 32'h5, 32'h0, 32'hf);

    op8("w8_multu_ff", 6'h19, 8'hff, 8'hff, 8'hfe, 8'h01);
    op8("w8_divu_200d7", 6'h1B, 8'd200, 8'd7, 8'd4, 8'd28);
    op8("w8_div_m100d7", 6'h1A, 8'h9c, 8'd7, 8'hfe, 8'hf2);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised multi-cycle multiply/divide companion to the single-cycle ALU. It implements the MIPS HI/LO operations: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO. Iterative shift-add multiply and restoring divide run over WIDTH cycles, and a combinational stall tells the pipeline control to hold any dependent instruction. The block sits beside the ALU in the execute stage and receives the same Func_in, A_in and B_in operands.

## Interface
- WIDTH, 32: operand, HI and LO width; must be ≥ 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

- Clk_in  input  1  clock; all state updates on the rising edge.
- Reset_in  input  1  synchronous, active-high reset.
- Valid_in  input  1  an instruction is presented on Func_in, A_in and B_in this cycle.
- Func_in  input  6  MIPS funct code: 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU; all other codes are ignored.
- A_in  input  WIDTH  rs operand.
- B_in  input  WIDTH  rt operand.
- O_out  output  WIDTH  MFHI/MFLO result; combinational.
- Hi_out  output  WIDTH  HI register.
- Lo_out  output  WIDTH  LO register.
- Busy_out  output  1  an operation is in flight (state RUN or FIX).
- Stall_out  output  1  the presented instruction is not accepted this cycle; combinational.

## Operation
- Reset values:
  - state = IDLE.
  - HI = LO = 0.
  - Busy_out = 0 and Stall_out = 0.
  - O_out = 0.
- Reset asserted mid-operation abandons the operation; HI/LO return to 0 on that edge.
- Stall_out = Valid_in & Busy_out & (Func_in is any of the 8 listed codes). Codes not in the list never stall.
- States:
  - IDLE: on Valid_in with MULT/MULTU/DIV/DIVU and no stall, the block latches operands and goes to RUN with counter = 0.
    - MULT/DIV latch |A| and |B| plus the result signs.
    - MULTU/DIVU latch A and B unchanged.
  - RUN: performs one iteration per cycle and increments the counter. After WIDTH iterations it goes to FIX.
    - Multiply: 2·WIDTH-bit shift-add accumulator.
    - Divide: restoring, one quotient bit per cycle.
  - FIX: applies the sign fix-up, writes HI/LO, then returns to IDLE.
- Sign rules:
  - Signed product: negated when A and B have opposite signs.
  - Signed quotient: negative when the operand signs differ.
  - Signed remainder: takes the sign of the dividend.
  - Widths: product is 2·WIDTH bits, HI = upper half, LO = lower half. Quotient and remainder are truncated to WIDTH bits.
- Divide by zero: same latency; FIX writes HI = original A_in and LO = all ones, for both signed and unsigned.
- Signed overflow (−2^(WIDTH−1) / −1): LO = 0x8000…0 and HI = 0; no exception is raised.
- MTHI / MTLO: write A_in to HI / LO on the next edge, only when not stalled; takes 1 cycle and Busy_out is not raised.
- MFHI / MFLO: when not stalled, O_out = HI / LO in the same cycle. Otherwise O_out = 0.

## Timing
- MULT/DIV family: accepted at edge k; RUN occupies edges k+1..k+WIDTH; FIX at edge k+WIDTH+1 writes HI/LO.
  - Busy_out is high after edge k through edge k+WIDTH+1, i.e. WIDTH+1 cycles.
  - The new HI/LO is visible on Hi_out/Lo_out from edge k+WIDTH+1.
  - The first non-stalled MFHI is in the cycle after edge k+WIDTH+1.
- Back-to-back: a MULT/DIV presented in the cycle after FIX is accepted. Any of the 8 codes presented while busy stalls and must be held by the upstream stage.
- Invalid operands or Func_in while Valid_in = 0 have no effect.

## Test plan
- Reset then MFHI/MFLO: Hi_out = Lo_out = 0, O_out = 0, Busy_out = 0.
- MULT 0xFFFFFFFF × 0x00000002 (−1 × 2): Busy_out high for 33 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. MULTU with the same operands gives HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV −7 / 2: LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). DIVU 7 / 0: HI = 7, LO = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MFLO issued each cycle after a MULT is accepted: Stall_out = 1 for 33 cycles. In the next cycle Stall_out = 0 and O_out = the new LO. MTHI 0x1234 after that: HI = 0x1234 one edge later.
- Reset asserted at RUN iteration 10: next edge state IDLE, HI = LO = 0, Busy_out = 0. A new MULTU 3 × 5 then yields LO = 15.
- WIDTH = 8 build: MULTU 0xFF × 0xFF gives HI = 0xFE, LO = 0x01 after 9 busy cycles. DIVU 200 / 7 gives LO = 28, HI = 4.
